// File: rtl/fp_mantissa_addsub_pipe_if.sv
// rtl/fp_mantissa_addsub_pipe_if.sv - operand/result handshake bundle for the mantissa add/sub stage
interface fp_mantissa_addsub_pipe_if #(
  parameter int MW = 48
);
  localparam int LW = $clog2(MW + 2);

  logic          valid_in;
  logic          ready_in;
  logic          op_sub;
  logic          signA;
  logic          signB;
  logic [MW-1:0] mag_M;
  logic [MW-1:0] mag_m;

  logic          valid_out;
  logic          ready_out;
  logic          sign;
  logic [MW:0]   sum;
  logic          zero;
  logic [LW-1:0] lzc;

  modport master (
    output valid_in, op_sub, signA, signB, mag_M, mag_m, ready_out,
    input  ready_in, valid_out, sign, sum, zero, lzc
  );

  modport slave (
    input  valid_in, op_sub, signA, signB, mag_M, mag_m, ready_out,
    output ready_in, valid_out, sign, sum, zero, lzc
  );
endinterface

// File: rtl/fp_mantissa_addsub_pipe.sv
// rtl/fp_mantissa_addsub_pipe.sv - signed-magnitude mantissa add/sub with LZC, 1 or 2 pipeline stages
module fp_mantissa_addsub_pipe #(
  parameter int MW     = 48,
  parameter int STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  fp_mantissa_addsub_pipe_if.slave    bus
);
  localparam int LW = $clog2(MW + 2);

  function automatic logic [LW-1:0] count_lz(input logic [MW:0] x);
    count_lz = LW'(MW + 1);
    for (int i = 0; i <= MW; i++) begin
      if (x[i]) count_lz = LW'(MW - i);
    end
  endfunction

  logic          eff_sign_b;
  logic          eff_sub;
  logic          mag_lt;
  logic [MW:0]   ext_M;
  logic [MW:0]   ext_m;
  logic [MW:0]   c_sum;
  logic          c_sign;
  logic          c_zero;

  always_comb begin
    eff_sign_b = bus.signB ^ bus.op_sub;
    eff_sub    = bus.signA ^ eff_sign_b;
    ext_M      = {1'b0, bus.mag_M};
    ext_m      = {1'b0, bus.mag_m};
    mag_lt     = ext_M < ext_m;
    c_sum      = '0;
    c_sign     = bus.signA;
    if (!eff_sub) begin
      c_sum  = ext_M + ext_m;
      c_sign = bus.signA;
    end else if (mag_lt) begin
      c_sum  = ext_m - ext_M;
      c_sign = eff_sign_b;
    end else begin
      c_sum  = ext_M - ext_m;
      c_sign = bus.signA;
    end
    c_zero = (c_sum == '0);
    // Exact cancellation yields +0; a true 0+0 keeps the sign of A.
    if (eff_sub && c_zero) c_sign = 1'b0;
  end

  logic          ld1;
  logic          v1;
  logic          s1_sign;
  logic [MW:0]   s1_sum;
  logic          s1_zero;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1      <= 1'b0;
      s1_sign <= 1'b0;
      s1_sum  <= '0;
      s1_zero <= 1'b0;
    end else if (ld1) begin
      v1 <= bus.valid_in;
      if (bus.valid_in) begin
        s1_sign <= c_sign;
        s1_sum  <= c_sum;
        s1_zero <= c_zero;
      end
    end
  end

  assign bus.ready_in = ld1;

  generate
    if (STAGES == 2) begin : g_two
      logic          ld2;
      logic          v2;
      logic          s2_sign;
      logic [MW:0]   s2_sum;
      logic          s2_zero;
      logic [LW-1:0] s2_lzc;

      // Ready ripples back combinationally: a stalled output freezes both stages.
      assign ld2 = !v2 || bus.ready_out;
      assign ld1 = !v1 || ld2;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          v2      <= 1'b0;
          s2_sign <= 1'b0;
          s2_sum  <= '0;
          s2_zero <= 1'b0;
          s2_lzc  <= '0;
        end else if (ld2) begin
          v2 <= v1;
          if (v1) begin
            s2_sign <= s1_sign;
            s2_sum  <= s1_sum;
            s2_zero <= s1_zero;
            s2_lzc  <= count_lz(s1_sum);
          end
        end
      end

      assign bus.valid_out = v2;
      assign bus.sign      = s2_sign;
      assign bus.sum       = s2_sum;
      assign bus.zero      = s2_zero;
      assign bus.lzc       = s2_lzc;
    end else if (STAGES == 1) begin : g_one
      logic [LW-1:0] s1_lzc;

      assign ld1 = !v1 || bus.ready_out;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          s1_lzc <= '0;
        end else if (ld1 && bus.valid_in) begin
          s1_lzc <= count_lz(c_sum);
        end
      end

      assign bus.valid_out = v1;
      assign bus.sign      = s1_sign;
      assign bus.sum       = s1_sum;
      assign bus.zero      = s1_zero;
      assign bus.lzc       = s1_lzc;
    end else begin : g_bad_stages
      $error("fp_mantissa_addsub_pipe: STAGES must be 1 or 2");
    end
  endgenerate
endmodule

// File: tb/tb_fp_mantissa_addsub_pipe.sv
// tb/tb_fp_mantissa_addsub_pipe.sv - bench for both pipeline depths against an integer-arithmetic model
module tb_fp_mantissa_addsub_pipe;
  localparam int MW = 24;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          valid_in = 1'b0;
  logic          op_sub = 1'b0;
  logic          sign_a = 1'b0;
  logic          sign_b = 1'b0;
  logic [MW-1:0] mag_a = '0;
  logic [MW-1:0] mag_b = '0;
  logic          ready_out2 = 1'b1;
  bit            rand_rdy = 1'b0;

  int            n_tests = 0;
  int            n_fail = 0;
  int            acc2 = 0;
  logic [31:0]   q1[$];
  logic [31:0]   q2[$];

  always #5 clk = ~clk;

  fp_mantissa_addsub_pipe_if #(.MW(MW)) bus1();
  fp_mantissa_addsub_pipe_if #(.MW(MW)) bus2();

  assign bus1.valid_in  = valid_in;
  assign bus1.op_sub    = op_sub;
  assign bus1.signA     = sign_a;
  assign bus1.signB     = sign_b;
  assign bus1.mag_M     = mag_a;
  assign bus1.mag_m     = mag_b;
  assign bus1.ready_out = 1'b1;
  assign bus2.valid_in  = valid_in;
  assign bus2.op_sub    = op_sub;
  assign bus2.signA     = sign_a;
  assign bus2.signB     = sign_b;
  assign bus2.mag_M     = mag_a;
  assign bus2.mag_m     = mag_b;
  assign bus2.ready_out = ready_out2;

  fp_mantissa_addsub_pipe #(.MW(MW), .STAGES(1)) u_dut1 (.clk(clk), .rstn(rstn), .bus(bus1));
  fp_mantissa_addsub_pipe #(.MW(MW), .STAGES(2)) u_dut2 (.clk(clk), .rstn(rstn), .bus(bus2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Result packed as {sign, sum[24:0], zero, lzc[4:0]}.
  function automatic logic [31:0] model(input logic sa, input logic sb, input logic os,
                                        input logic [MW-1:0] a, input logic [MW-1:0] b);
    longint va, vb, r, mag, tmp;
    logic   sgn;
    int     lz;
    va  = sa ? -longint'(a) : longint'(a);
    vb  = (sb ^ os) ? -longint'(b) : longint'(b);
    r   = va + vb;
    mag = (r < 0) ? -r : r;
    if (r < 0)      sgn = 1'b1;
    else if (r > 0) sgn = 1'b0;
    else            sgn = (sa == (sb ^ os)) ? sa : 1'b0;
    if (mag == 0) lz = MW + 1;
    else begin
      lz  = 0;
      tmp = mag;
      while (tmp < (longint'(1) << MW)) begin
        tmp = tmp << 1;
        lz++;
      end
    end
    return {sgn, mag[MW:0], (mag == 0), lz[4:0]};
  endfunction

  task automatic cmp_out(input string tag, input logic [31:0] e, input logic s,
                         input logic [MW:0] su, input logic z, input logic [4:0] l);
    check({tag, " sign"}, s, e[31]);
    check({tag, " sum"}, su, e[30:6]);
    check({tag, " zero"}, z, e[5]);
    check({tag, " lzc"}, l, e[4:0]);
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      q1.delete();
    end else begin
      if (bus1.valid_out) begin
        if (q1.size() == 0) check("dut1 valid_out with nothing pending", bus1.valid_out, 0);
        else begin
          cmp_out("dut1 out", q1[0], bus1.sign, bus1.sum, bus1.zero, bus1.lzc);
          void'(q1.pop_front());
        end
      end
      if (valid_in && bus1.ready_in) q1.push_back(model(sign_a, sign_b, op_sub, mag_a, mag_b));
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      q2.delete();
    end else begin
      if (bus2.valid_out) begin
        if (q2.size() == 0) check("dut2 valid_out with nothing pending", bus2.valid_out, 0);
        else begin
          cmp_out("dut2 out", q2[0], bus2.sign, bus2.sum, bus2.zero, bus2.lzc);
          if (bus2.ready_out) void'(q2.pop_front());
        end
      end
      if (valid_in && bus2.ready_in) begin
        q2.push_back(model(sign_a, sign_b, op_sub, mag_a, mag_b));
        acc2++;
      end
    end
  end

  function automatic logic [MW-1:0] rand_mag();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return MW'($urandom_range(0, 15));
      default: return MW'($urandom());
    endcase
  endfunction

  task automatic send_op(input logic sa, input logic sb, input logic os,
                         input logic [MW-1:0] a, input logic [MW-1:0] b);
    bit got = 1'b0;
    sign_a = sa; sign_b = sb; op_sub = os; mag_a = a; mag_b = b;
    valid_in = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      got = bus2.ready_in;
      @(posedge clk);
      #1;
      if (rand_rdy) ready_out2 = ($urandom_range(0, 3) != 0);
    end
    valid_in = 1'b0;
    check("send_op accepted", got, 1);
  endtask

  task automatic send_rand();
    logic [MW-1:0] a, b;
    a = rand_mag();
    b = ($urandom_range(0, 4) == 0) ? a : rand_mag();
    send_op(1'($urandom()), 1'($urandom()), 1'($urandom()), a, b);
  endtask

  task automatic directed(input logic sa, input logic sb, input logic os,
                          input logic [MW-1:0] a, input logic [MW-1:0] b,
                          input logic [MW:0] esum, input logic esign, input logic ezero,
                          input logic [4:0] elz);
    send_op(sa, sb, os, a, b);
    check("lat s1 dut1 valid", bus1.valid_out, 1);
    check("lat s1 dut2 valid", bus2.valid_out, 0);
    cmp_out("dir dut1", {esign, esum, ezero, elz}, bus1.sign, bus1.sum, bus1.zero, bus1.lzc);
    @(posedge clk); #1;
    check("lat s2 dut2 valid", bus2.valid_out, 1);
    check("lat s2 dut1 valid", bus1.valid_out, 0);
    cmp_out("dir dut2", {esign, esum, ezero, elz}, bus2.sign, bus2.sum, bus2.zero, bus2.lzc);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc_base;
    repeat (2) @(posedge clk);
    #1;
    check("reset dut2 valid_out", bus2.valid_out, 0);
    check("reset dut2 ready_in", bus2.ready_in, 1);
    cmp_out("reset dut2", 32'h0, bus2.sign, bus2.sum, bus2.zero, bus2.lzc);
    check("reset dut1 valid_out", bus1.valid_out, 0);
    cmp_out("reset dut1", 32'h0, bus1.sign, bus1.sum, bus1.zero, bus1.lzc);
    rstn = 1'b1;
    @(posedge clk); #1;

    directed(0, 0, 0, 24'h800000, 24'h800000, 25'h1000000, 0, 0, 5'd0);
    directed(1, 0, 0, 24'h654321, 24'h654321, 25'h0, 0, 1, 5'd25);
    directed(0, 1, 0, 24'h400000, 24'h800000, 25'h400000, 1, 0, 5'd2);
    directed(0, 0, 1, 24'h000003, 24'h000001, 25'h2, 0, 0, 5'd23);
    directed(0, 1, 1, 24'h000003, 24'h000001, 25'h4, 0, 0, 5'd22);
    directed(1, 1, 0, 24'h000000, 24'h000000, 25'h0, 1, 1, 5'd25);
    directed(0, 0, 0, 24'h000001, 24'h000000, 25'h1, 0, 0, 5'd24);

    acc_base = acc2;
    ready_out2 = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) send_rand();
      end
      begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("bp accepted before stall", acc2 - acc_base, 2);
        check("bp ready_in low", bus2.ready_in, 0);
        @(posedge clk); #1;
        ready_out2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("bp no gap valid_out", bus2.valid_out, 1);
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("bp drained", q2.size(), 0);

    send_rand();
    send_rand();
    rstn = 1'b0;
    #1;
    check("rst mid dut1 valid_out", bus1.valid_out, 0);
    check("rst mid dut2 valid_out", bus2.valid_out, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst no stale dut1", bus1.valid_out, 0);
      check("rst no stale dut2", bus2.valid_out, 0);
    end
    @(posedge clk); #1;
    directed(0, 1, 0, 24'h400000, 24'h800000, 25'h400000, 1, 0, 5'd2);

    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      send_rand();
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
          ready_out2 = ($urandom_range(0, 3) != 0);
        end
      end
    end
    rand_rdy = 1'b0;
    ready_out2 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("final dut1 queue empty", q1.size(), 0);
    check("final dut2 queue empty", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
